// File: rtl/unidade_controle_sequencia.sv
// -----------------------------------------------------------------------------
// unidade_controle_sequencia
// Moore control unit for the colour-sequence game. It reads the status flags of
// the datapath (fluxo_dados) and issues every zera/conta/registra/enable
// command. Each round it replays the stored sequence on the RGB LED, checks the
// player's repetition and finally records one new colour at the end of the
// sequence. The game ends in won, lost (wrong colour) or lost (timeout).
//
// All commands are registered: they are produced from the next-state value in
// the same clocked block that updates the state register, so each output is a
// pure function of the state held in r_estado, with no decode glitches.
// -----------------------------------------------------------------------------
module unidade_controle_sequencia (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       igual,
  input  logic       fim_jogo,
  input  logic       enderecoIgualLimite,
  input  logic       fim_sequencia,
  input  logic       jogada_feita,
  input  logic       timeout,
  input  logic       timeout_led,
  input  logic       timeout_habilitado,
  output logic       zera_endereco,
  output logic       conta_endereco,
  output logic       zera_limite,
  output logic       conta_limite,
  output logic       zeraR,
  output logic       registrarR,
  output logic       zera_s_timeout,
  output logic       enable_timeout,
  output logic       zera_s_led,
  output logic       enable_led,
  output logic       zera_modo,
  output logic       registra_modo,
  output logic       conf_leds,
  output logic       registra_jogada,
  output logic       pronto,
  output logic       ganhou,
  output logic       perdeu,
  output logic       db_timeout,
  output logic [4:0] db_estado
);

  // State codes are visible on db_estado, so they are fixed values.
  typedef enum logic [4:0] {
    INICIAL        = 5'h00,
    PREPARACAO     = 5'h01,
    INICIO_EXIBE   = 5'h02,
    MOSTRA_LED     = 5'h03,
    ZERA_LED       = 5'h04,
    APAGA_LED      = 5'h05,
    PROXIMO_LED    = 5'h06,
    INICIO_RODADA  = 5'h07,
    ESPERA_JOGADA  = 5'h08,
    REGISTRA       = 5'h09,
    COMPARACAO     = 5'h0A,
    PROXIMA_JOGADA = 5'h0B,
    AVANCA_LIMITE  = 5'h0C,
    ESPERA_NOVA    = 5'h0D,
    ESCREVE_NOVA   = 5'h0E,
    FIM_ACERTOU    = 5'h1C,
    FIM_ERROU      = 5'h1D,
    FIM_TIMEOUT    = 5'h1E
  } estado_t;

  // Bit positions inside the packed command word.
  localparam int B_ZERA_END    = 17;
  localparam int B_CONTA_END   = 16;
  localparam int B_ZERA_LIM    = 15;
  localparam int B_CONTA_LIM   = 14;
  localparam int B_ZERA_R      = 13;
  localparam int B_REGISTRA_R  = 12;
  localparam int B_ZERA_TMO    = 11;
  localparam int B_EN_TMO      = 10;
  localparam int B_ZERA_LED    = 9;
  localparam int B_EN_LED      = 8;
  localparam int B_ZERA_MODO   = 7;
  localparam int B_REG_MODO    = 6;
  localparam int B_CONF_LEDS   = 5;
  localparam int B_REG_JOGADA  = 4;
  localparam int B_PRONTO      = 3;
  localparam int B_GANHOU      = 2;
  localparam int B_PERDEU      = 1;
  localparam int B_DB_TIMEOUT  = 0;

  estado_t     r_estado;
  estado_t     w_proximo;
  logic [17:0] r_cmd;
  logic [17:0] w_cmd_proximo;
  logic        w_timeout_valido;

  // Moore output decode: the set of commands asserted while in state e.
  function automatic logic [17:0] decodifica(input estado_t e);
    logic [17:0] v;
    v = 18'd0;
    case (e)
      INICIAL: begin
        v[B_ZERA_MODO] = 1'b1;
      end
      PREPARACAO: begin
        v[B_ZERA_END]  = 1'b1;
        v[B_ZERA_LIM]  = 1'b1;
        v[B_ZERA_R]    = 1'b1;
        v[B_ZERA_TMO]  = 1'b1;
        v[B_ZERA_LED]  = 1'b1;
        v[B_REG_MODO]  = 1'b1;
      end
      INICIO_EXIBE: begin
        v[B_ZERA_END]  = 1'b1;
        v[B_ZERA_LED]  = 1'b1;
      end
      MOSTRA_LED: begin
        v[B_CONF_LEDS] = 1'b1;
        v[B_EN_LED]    = 1'b1;
      end
      ZERA_LED: begin
        v[B_ZERA_LED]  = 1'b1;
      end
      APAGA_LED: begin
        v[B_EN_LED]    = 1'b1;
      end
      PROXIMO_LED: begin
        v[B_CONTA_END] = 1'b1;
        v[B_ZERA_LED]  = 1'b1;
      end
      INICIO_RODADA: begin
        v[B_ZERA_END]  = 1'b1;
        v[B_ZERA_R]    = 1'b1;
        v[B_ZERA_TMO]  = 1'b1;
      end
      ESPERA_JOGADA: begin
        v[B_EN_TMO]    = 1'b1;
      end
      REGISTRA: begin
        v[B_REGISTRA_R] = 1'b1;
        v[B_ZERA_TMO]   = 1'b1;
      end
      COMPARACAO: begin
        v = 18'd0;
      end
      PROXIMA_JOGADA: begin
        v[B_CONTA_END] = 1'b1;
      end
      AVANCA_LIMITE: begin
        // Address and limit advance together so endereco == limite afterwards,
        // pointing at the empty slot the new colour goes into.
        v[B_CONTA_END] = 1'b1;
        v[B_CONTA_LIM] = 1'b1;
        v[B_ZERA_TMO]  = 1'b1;
      end
      ESPERA_NOVA: begin
        v[B_EN_TMO]    = 1'b1;
      end
      ESCREVE_NOVA: begin
        v[B_REG_JOGADA] = 1'b1;
      end
      FIM_ACERTOU: begin
        v[B_PRONTO]    = 1'b1;
        v[B_GANHOU]    = 1'b1;
      end
      FIM_ERROU: begin
        v[B_PRONTO]    = 1'b1;
        v[B_PERDEU]    = 1'b1;
      end
      FIM_TIMEOUT: begin
        v[B_PRONTO]     = 1'b1;
        v[B_PERDEU]     = 1'b1;
        v[B_DB_TIMEOUT] = 1'b1;
      end
      default: begin
        v = 18'd0;
      end
    endcase
    return v;
  endfunction

  // The player timeout only matters when the mode enabled it; the counter
  // itself keeps running either way.
  assign w_timeout_valido = timeout & timeout_habilitado;

  // Next-state logic: one transition rule per state, press beats timeout.
  always_comb begin
    w_proximo = r_estado;
    case (r_estado)
      INICIAL: begin
        if (iniciar) w_proximo = PREPARACAO;
        else         w_proximo = INICIAL;
      end
      PREPARACAO:    w_proximo = INICIO_EXIBE;
      INICIO_EXIBE:  w_proximo = MOSTRA_LED;
      MOSTRA_LED: begin
        if (timeout_led) w_proximo = ZERA_LED;
        else             w_proximo = MOSTRA_LED;
      end
      ZERA_LED:      w_proximo = APAGA_LED;
      APAGA_LED: begin
        if (timeout_led && fim_sequencia)  w_proximo = INICIO_RODADA;
        else if (timeout_led)              w_proximo = PROXIMO_LED;
        else                               w_proximo = APAGA_LED;
      end
      PROXIMO_LED:   w_proximo = MOSTRA_LED;
      INICIO_RODADA: w_proximo = ESPERA_JOGADA;
      ESPERA_JOGADA: begin
        if (jogada_feita)          w_proximo = REGISTRA;
        else if (w_timeout_valido) w_proximo = FIM_TIMEOUT;
        else                       w_proximo = ESPERA_JOGADA;
      end
      REGISTRA:      w_proximo = COMPARACAO;
      COMPARACAO: begin
        // enderecoIgualLimite is the same comparator as fim_sequencia; the
        // datapath exposes it under this name for the compare step.
        if (!igual)                    w_proximo = FIM_ERROU;
        else if (!enderecoIgualLimite) w_proximo = PROXIMA_JOGADA;
        else if (fim_jogo)             w_proximo = FIM_ACERTOU;
        else                           w_proximo = AVANCA_LIMITE;
      end
      PROXIMA_JOGADA: w_proximo = ESPERA_JOGADA;
      AVANCA_LIMITE:  w_proximo = ESPERA_NOVA;
      ESPERA_NOVA: begin
        if (jogada_feita)          w_proximo = ESCREVE_NOVA;
        else if (w_timeout_valido) w_proximo = FIM_TIMEOUT;
        else                       w_proximo = ESPERA_NOVA;
      end
      ESCREVE_NOVA:   w_proximo = INICIO_EXIBE;
      FIM_ACERTOU, FIM_ERROU, FIM_TIMEOUT: begin
        if (iniciar) w_proximo = PREPARACAO;
        else         w_proximo = r_estado;
      end
      default:        w_proximo = INICIAL;
    endcase
  end

  // Command word for the state being entered.
  always_comb begin
    w_cmd_proximo = decodifica(w_proximo);
  end

  // State register plus registered commands; reset clears every output.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_estado <= INICIAL;
      r_cmd    <= 18'd0;
    end else begin
      r_estado <= w_proximo;
      r_cmd    <= w_cmd_proximo;
    end
  end

  assign zera_endereco   = r_cmd[B_ZERA_END];
  assign conta_endereco  = r_cmd[B_CONTA_END];
  assign zera_limite     = r_cmd[B_ZERA_LIM];
  assign conta_limite    = r_cmd[B_CONTA_LIM];
  assign zeraR           = r_cmd[B_ZERA_R];
  assign registrarR      = r_cmd[B_REGISTRA_R];
  assign zera_s_timeout  = r_cmd[B_ZERA_TMO];
  assign enable_timeout  = r_cmd[B_EN_TMO];
  assign zera_s_led      = r_cmd[B_ZERA_LED];
  assign enable_led      = r_cmd[B_EN_LED];
  assign zera_modo       = r_cmd[B_ZERA_MODO];
  assign registra_modo   = r_cmd[B_REG_MODO];
  assign conf_leds       = r_cmd[B_CONF_LEDS];
  assign registra_jogada = r_cmd[B_REG_JOGADA];
  assign pronto          = r_cmd[B_PRONTO];
  assign ganhou          = r_cmd[B_GANHOU];
  assign perdeu          = r_cmd[B_PERDEU];
  assign db_timeout      = r_cmd[B_DB_TIMEOUT];
  assign db_estado       = r_estado;

endmodule

// File: tb/tb_unidade_controle_sequencia.sv
// -----------------------------------------------------------------------------
// Bench for unidade_controle_sequencia: directed game scenarios with literal
// expectations, then randomized status flags. A reference model holds the
// current state as a plain integer code and looks up its command set from a
// table; every cycle the DUT outputs are compared against it.
// -----------------------------------------------------------------------------
module tb_unidade_controle_sequencia;

  logic clock = 1'b0;
  logic reset, iniciar, igual, fim_jogo, enderecoIgualLimite, fim_sequencia;
  logic jogada_feita, timeout, timeout_led, timeout_habilitado;
  logic zera_endereco, conta_endereco, zera_limite, conta_limite, zeraR, registrarR;
  logic zera_s_timeout, enable_timeout, zera_s_led, enable_led, zera_modo, registra_modo;
  logic conf_leds, registra_jogada, pronto, ganhou, perdeu, db_timeout;
  logic [4:0] db_estado;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state
  int  m_state = 0;
  bit  m_after_reset = 1'b1;

  always #5 clock = ~clock;

  unidade_controle_sequencia dut (
    .clock(clock), .reset(reset), .iniciar(iniciar), .igual(igual),
    .fim_jogo(fim_jogo), .enderecoIgualLimite(enderecoIgualLimite),
    .fim_sequencia(fim_sequencia), .jogada_feita(jogada_feita),
    .timeout(timeout), .timeout_led(timeout_led),
    .timeout_habilitado(timeout_habilitado),
    .zera_endereco(zera_endereco), .conta_endereco(conta_endereco),
    .zera_limite(zera_limite), .conta_limite(conta_limite),
    .zeraR(zeraR), .registrarR(registrarR),
    .zera_s_timeout(zera_s_timeout), .enable_timeout(enable_timeout),
    .zera_s_led(zera_s_led), .enable_led(enable_led),
    .zera_modo(zera_modo), .registra_modo(registra_modo),
    .conf_leds(conf_leds), .registra_jogada(registra_jogada),
    .pronto(pronto), .ganhou(ganhou), .perdeu(perdeu),
    .db_timeout(db_timeout), .db_estado(db_estado)
  );

  // Output names in table order (MSB first) for readable model entries.
  function automatic logic [17:0] bitn(input int idx_from_msb);
    logic [17:0] one;
    one = 18'd1;
    return one << (17 - idx_from_msb);
  endfunction
  // indices: 0 zera_endereco 1 conta_endereco 2 zera_limite 3 conta_limite
  // 4 zeraR 5 registrarR 6 zera_s_timeout 7 enable_timeout 8 zera_s_led
  // 9 enable_led 10 zera_modo 11 registra_modo 12 conf_leds 13 registra_jogada
  // 14 pronto 15 ganhou 16 perdeu 17 db_timeout

  function automatic logic [17:0] table_out(input int s);
    case (s)
      'h00: return bitn(10);
      'h01: return bitn(0) | bitn(2) | bitn(4) | bitn(6) | bitn(8) | bitn(11);
      'h02: return bitn(0) | bitn(8);
      'h03: return bitn(12) | bitn(9);
      'h04: return bitn(8);
      'h05: return bitn(9);
      'h06: return bitn(1) | bitn(8);
      'h07: return bitn(0) | bitn(4) | bitn(6);
      'h08: return bitn(7);
      'h09: return bitn(5) | bitn(6);
      'h0A: return 18'd0;
      'h0B: return bitn(1);
      'h0C: return bitn(1) | bitn(3) | bitn(6);
      'h0D: return bitn(7);
      'h0E: return bitn(13);
      'h1C: return bitn(14) | bitn(15);
      'h1D: return bitn(14) | bitn(16);
      'h1E: return bitn(14) | bitn(16) | bitn(17);
      default: return 18'd0;
    endcase
  endfunction

  function automatic int rule_next(input int s);
    bit pressed, expired;
    pressed = jogada_feita;
    expired = timeout && timeout_habilitado;
    case (s)
      'h00: return iniciar ? 'h01 : 'h00;
      'h01: return 'h02;
      'h02: return 'h03;
      'h03: return timeout_led ? 'h04 : 'h03;
      'h04: return 'h05;
      'h05: return !timeout_led ? 'h05 : (fim_sequencia ? 'h07 : 'h06);
      'h06: return 'h03;
      'h07: return 'h08;
      'h08: return pressed ? 'h09 : (expired ? 'h1E : 'h08);
      'h09: return 'h0A;
      'h0A: begin
        if (!igual) return 'h1D;
        if (!fim_sequencia) return 'h0B;
        return fim_jogo ? 'h1C : 'h0C;
      end
      'h0B: return 'h08;
      'h0C: return 'h0D;
      'h0D: return pressed ? 'h0E : (expired ? 'h1E : 'h0D);
      'h0E: return 'h02;
      'h1C, 'h1D, 'h1E: return iniciar ? 'h01 : s;
      default: return 'h00;
    endcase
  endfunction

  function automatic logic [22:0] dut_word();
    return {zera_endereco, conta_endereco, zera_limite, conta_limite, zeraR,
            registrarR, zera_s_timeout, enable_timeout, zera_s_led, enable_led,
            zera_modo, registra_modo, conf_leds, registra_jogada, pronto,
            ganhou, perdeu, db_timeout, db_estado};
  endfunction

  // One clock: model steps at the rising edge, compare at the falling edge.
  task automatic tick();
    logic [22:0] exp_w;
    logic [4:0]  code;
    @(posedge clock);
    if (reset) begin
      m_state = 0;
      m_after_reset = 1'b1;
    end else begin
      m_state = rule_next(m_state);
      m_after_reset = 1'b0;
    end
    @(negedge clock);
    code = m_state[4:0];
    exp_w = m_after_reset ? 23'd0 : {table_out(m_state), code};
    vectors++;
    if (dut_word() !== exp_w) begin
      miscompares++;
      $display("FAIL model_cmp t=%0t got=%h expected=%h", $time, dut_word(), exp_w);
    end
  endtask

  task automatic lit(input string name, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s got=%h expected=%h", name, got, want);
    end
  endtask

  task automatic clear_inputs();
    iniciar = 1'b0; igual = 1'b0; fim_jogo = 1'b0; fim_sequencia = 1'b0;
    enderecoIgualLimite = 1'b0; jogada_feita = 1'b0; timeout = 1'b0;
    timeout_led = 1'b0; timeout_habilitado = 1'b0;
  endtask

  // From 02: single-colour replay 02->03->04->05->07->08.
  task automatic replay_to_wait();
    timeout_led = 1'b1; fim_sequencia = 1'b1; enderecoIgualLimite = 1'b1;
    repeat (5) tick();
    timeout_led = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    clear_inputs();
    tick(); tick();
    lit("reset_estado", {27'd0, db_estado}, 32'h00);
    lit("reset_outputs", {9'd0, dut_word()}, 32'd0);

    // Start: 00 -> 01 -> 02 -> 03 with the LED on
    reset = 1'b0; iniciar = 1'b1;
    tick();
    lit("prep_estado", {27'd0, db_estado}, 32'h01);
    lit("prep_registra_modo", {31'd0, registra_modo}, 32'd1);
    iniciar = 1'b0;
    tick(); lit("inicio_exibe", {27'd0, db_estado}, 32'h02);
    tick(); lit("mostra_conf_leds", {26'd0, conf_leds, db_estado}, 32'h23);
    timeout_led = 1'b1; fim_sequencia = 1'b1; enderecoIgualLimite = 1'b1;
    repeat (4) tick();
    timeout_led = 1'b0;
    lit("espera_jogada", {27'd0, db_estado}, 32'h08);

    // Timeout ignored while disabled, then reset from inside the round
    timeout = 1'b1; timeout_habilitado = 1'b0;
    repeat (3) tick();
    lit("hab0_stays", {27'd0, db_estado}, 32'h08);
    reset = 1'b1; tick();
    lit("midround_reset", {9'd0, dut_word()}, 32'd0);
    reset = 1'b0; timeout = 1'b0; iniciar = 1'b1; tick(); iniciar = 1'b0; tick();
    replay_to_wait();

    // Press and timeout together: press wins, then wrong colour -> 1D
    jogada_feita = 1'b1; timeout = 1'b1; timeout_habilitado = 1'b1;
    tick();
    lit("press_wins", {27'd0, db_estado}, 32'h09);
    jogada_feita = 1'b0; timeout = 1'b0;
    tick(); lit("comparacao", {27'd0, db_estado}, 32'h0A);
    igual = 1'b0; tick();
    lit("errou", {29'd0, pronto, perdeu, db_timeout}, 32'h6);
    lit("errou_estado", {27'd0, db_estado}, 32'h1D);

    // Restart, then player timeout -> 1E
    iniciar = 1'b1; tick(); iniciar = 1'b0; tick();
    replay_to_wait();
    timeout = 1'b1; tick();
    lit("timeout_end", {26'd0, db_timeout, db_estado}, 32'h3E);
    timeout = 1'b0;

    // Correct round, new colour written, replay, then win
    iniciar = 1'b1; tick(); iniciar = 1'b0; tick();
    replay_to_wait();
    jogada_feita = 1'b1; tick(); jogada_feita = 1'b0; tick();
    igual = 1'b1; fim_jogo = 1'b0; tick();
    lit("avanca_limite", {29'd0, conta_limite, conta_endereco, zera_s_timeout}, 32'h7);
    tick(); lit("espera_nova", {27'd0, db_estado}, 32'h0D);
    jogada_feita = 1'b1; tick(); jogada_feita = 1'b0;
    lit("escreve_nova", {26'd0, registra_jogada, db_estado}, 32'h2E);
    tick(); lit("replay_again", {26'd0, registra_jogada, db_estado}, 32'h02);
    replay_to_wait();
    jogada_feita = 1'b1; tick(); jogada_feita = 1'b0; tick();
    fim_jogo = 1'b1; tick();
    lit("ganhou", {27'd0, db_estado}, 32'h1C);
    lit("ganhou_flags", {29'd0, pronto, ganhou, perdeu}, 32'h6);

    // Randomized flags
    for (int i = 0; i < 4000; i++) begin
      reset        = ($urandom_range(0, 99) == 0);
      iniciar      = ($urandom_range(0, 3) == 0);
      igual        = ($urandom_range(0, 3) != 0);
      fim_jogo     = ($urandom_range(0, 2) == 0);
      fim_sequencia = $urandom_range(0, 1);
      enderecoIgualLimite = fim_sequencia;
      jogada_feita = ($urandom_range(0, 3) == 0);
      timeout      = ($urandom_range(0, 7) == 0);
      timeout_led  = $urandom_range(0, 1);
      timeout_habilitado = $urandom_range(0, 1);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
